// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the MEM pipeline stage.
package mem_stage_pkg;

  localparam int unsigned MEM_XLEN    = 64;
  localparam int unsigned MEM_TIMEOUT = 16;
  localparam int unsigned RD_W        = 5;

  // Memory access FSM: idle/first cycle of an access, or waiting for ack
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mem_state_t;

  // Bubble values written into the MEM/WB control fields
  localparam logic            NOP_CTRL = 1'b0;
  localparam logic [RD_W-1:0] NOP_RD   = '0;

endpackage

// File: rtl/mem_stage_memwb_reg.sv
// MEM/WB pipeline register. A bubble clears the control fields and rd while the
// data fields hold; read data only updates when a load completes.
module memwb_reg
  import mem_stage_pkg::*;
#(
  parameter int unsigned XLEN = MEM_XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            bubble,
  input  logic            load_done,
  input  logic            mem_to_reg_in,
  input  logic            reg_write_in,
  input  logic [RD_W-1:0] rd_in,
  input  logic [XLEN-1:0] alu_result_in,
  input  logic [XLEN-1:0] rdata_in,
  output logic            mem_to_reg_out,
  output logic            reg_write_out,
  output logic [RD_W-1:0] rd_out,
  output logic [XLEN-1:0] alu_result_out,
  output logic [XLEN-1:0] read_data_out
);

  logic            mem_to_reg_q, mem_to_reg_d;
  logic            reg_write_q,  reg_write_d;
  logic [RD_W-1:0] rd_q,         rd_d;
  logic [XLEN-1:0] alu_result_q, alu_result_d;
  logic [XLEN-1:0] read_data_q,  read_data_d;

  // Next-state: bubble or capture the EX/MEM payload
  always_comb begin
    mem_to_reg_d = NOP_CTRL;
    reg_write_d  = NOP_CTRL;
    rd_d         = NOP_RD;
    alu_result_d = alu_result_q;
    read_data_d  = read_data_q;
    if (!bubble) begin
      mem_to_reg_d = mem_to_reg_in;
      reg_write_d  = reg_write_in;
      rd_d         = rd_in;
      alu_result_d = alu_result_in;
      if (load_done) begin
        read_data_d = rdata_in;
      end
    end
  end

  // Register update with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_to_reg_q <= 1'b0;
      reg_write_q  <= 1'b0;
      rd_q         <= '0;
      alu_result_q <= '0;
      read_data_q  <= '0;
    end else begin
      mem_to_reg_q <= mem_to_reg_d;
      reg_write_q  <= reg_write_d;
      rd_q         <= rd_d;
      alu_result_q <= alu_result_d;
      read_data_q  <= read_data_d;
    end
  end

  assign mem_to_reg_out = mem_to_reg_q;
  assign reg_write_out  = reg_write_q;
  assign rd_out         = rd_q;
  assign alu_result_out = alu_result_q;
  assign read_data_out  = read_data_q;

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: data-memory req/ack access with wait-state stall and
// timeout abort, branch resolution, and the MEM/WB register.
// Optional macro MEM_ALIGN_CHECK_EN: misaligned accesses (addr[2:0] != 0) are
// rejected with a bus_err pulse and a MEM/WB bubble instead of reaching memory.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned XLEN    = MEM_XLEN,
  parameter int unsigned TIMEOUT = MEM_TIMEOUT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            mem_to_reg_d3,
  input  logic            reg_write_d3,
  input  logic            branch_d3,
  input  logic            mem_read_d3,
  input  logic            mem_write_d3,
  input  logic [XLEN-1:0] pc_branch_d3,
  input  logic [XLEN-1:0] alu_result_d3,
  input  logic            alu_zero_d3,
  input  logic [XLEN-1:0] rs2_data_d3,
  input  logic [RD_W-1:0] rd_d3,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic            dmem_ack,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            stall,
  output logic            pc_src,
  output logic [XLEN-1:0] pc_target,
  output logic            bus_err,
  output logic            mem_to_reg_d4,
  output logic            reg_write_d4,
  output logic [XLEN-1:0] read_data_d4,
  output logic [XLEN-1:0] alu_result_d4,
  output logic [RD_W-1:0] rd_d4
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  mem_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic             mem_op;
  logic             misalign;
  logic             done;
  logic             timeout;
  logic             bubble;
  logic             load_done;

  assign mem_op = mem_read_d3 | mem_write_d3;

`ifdef MEM_ALIGN_CHECK_EN
  assign misalign = mem_op & (alu_result_d3[2:0] != 3'b000);
`else
  assign misalign = 1'b0;
`endif

  // Access FSM next-state, wait counter and request; reset blanks the request
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dmem_req = 1'b0;
    done     = 1'b0;
    timeout  = 1'b0;
    if (!rst) begin
      case (state_q)
        IDLE: begin
          if (mem_op && !misalign) begin
            dmem_req = 1'b1;
            if (dmem_ack) begin
              done = 1'b1;
            end else begin
              state_d = WAIT;
              cnt_d   = CNT_W'(1);
            end
          end
        end
        WAIT: begin
          dmem_req = 1'b1;
          if (dmem_ack) begin
            // ack on the final counted cycle still counts as success
            done    = 1'b1;
            state_d = IDLE;
            cnt_d   = '0;
          end else if (cnt_q == CNT_W'(TIMEOUT)) begin
            timeout = 1'b1;
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // FSM state and wait counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign dmem_we    = dmem_req & mem_write_d3;
  assign dmem_addr  = alu_result_d3;
  assign dmem_wdata = rs2_data_d3;

  assign stall   = dmem_req & ~done & ~timeout;
  assign bus_err = ~rst & (timeout | misalign);

  // Branches carry no memory op, so resolution is never held by stall
  assign pc_src    = branch_d3 & alu_zero_d3;
  assign pc_target = pc_branch_d3;

  // A write with mem_read also set is treated purely as a write
  assign bubble    = stall | timeout | misalign;
  assign load_done = done & mem_read_d3 & ~mem_write_d3;

  memwb_reg #(
    .XLEN(XLEN)
  ) u_memwb_reg (
    .clk           (clk),
    .rst           (rst),
    .bubble        (bubble),
    .load_done     (load_done),
    .mem_to_reg_in (mem_to_reg_d3),
    .reg_write_in  (reg_write_d3),
    .rd_in         (rd_d3),
    .alu_result_in (alu_result_d3),
    .rdata_in      (dmem_rdata),
    .mem_to_reg_out(mem_to_reg_d4),
    .reg_write_out (reg_write_d4),
    .rd_out        (rd_d4),
    .alu_result_out(alu_result_d4),
    .read_data_out (read_data_d4)
  );

endmodule

// File: tb/tb_mem_stage.sv
// Testbench for mem_stage: directed scenarios plus randomized instructions with
// random memory latency, checked against a transaction-level model.
module tb_mem_stage;

  localparam int unsigned XLEN    = 64;
  localparam int unsigned TIMEOUT = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic            mem_to_reg_d3, reg_write_d3, branch_d3, mem_read_d3, mem_write_d3;
  logic [XLEN-1:0] pc_branch_d3, alu_result_d3, rs2_data_d3;
  logic            alu_zero_d3;
  logic [4:0]      rd_d3;
  logic            dmem_req, dmem_we, dmem_ack;
  logic [XLEN-1:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic            stall, pc_src, bus_err;
  logic [XLEN-1:0] pc_target;
  logic            mem_to_reg_d4, reg_write_d4;
  logic [XLEN-1:0] read_data_d4, alu_result_d4;
  logic [4:0]      rd_d4;

  int unsigned total = 0;
  int unsigned bad   = 0;

  // Model of the held MEM/WB data fields
  logic [XLEN-1:0] exp_alu;
  logic [XLEN-1:0] exp_rdata;

  mem_stage #(.XLEN(XLEN), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .mem_to_reg_d3(mem_to_reg_d3), .reg_write_d3(reg_write_d3), .branch_d3(branch_d3),
    .mem_read_d3(mem_read_d3), .mem_write_d3(mem_write_d3),
    .pc_branch_d3(pc_branch_d3), .alu_result_d3(alu_result_d3), .alu_zero_d3(alu_zero_d3),
    .rs2_data_d3(rs2_data_d3), .rd_d3(rd_d3),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .stall(stall), .pc_src(pc_src), .pc_target(pc_target), .bus_err(bus_err),
    .mem_to_reg_d4(mem_to_reg_d4), .reg_write_d4(reg_write_d4),
    .read_data_d4(read_data_d4), .alu_result_d4(alu_result_d4), .rd_d4(rd_d4)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Compare the whole MEM/WB register against the model
  task automatic check_d4(input string tag, input logic m2r, input logic rw, input logic [4:0] rd);
    check_val({tag, ".mem_to_reg_d4"}, XLEN'(mem_to_reg_d4), XLEN'(m2r));
    check_val({tag, ".reg_write_d4"},  XLEN'(reg_write_d4),  XLEN'(rw));
    check_val({tag, ".rd_d4"},         XLEN'(rd_d4),         XLEN'(rd));
    check_val({tag, ".alu_result_d4"}, alu_result_d4,        exp_alu);
    check_val({tag, ".read_data_d4"},  read_data_d4,         exp_rdata);
  endtask

  function automatic logic [XLEN-1:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  // One instruction held in EX/MEM until it leaves; k = cycle (0-based) on which memory acks.
  // Called at a negedge; returns at a negedge.
  task automatic run_instr(input string tag, input logic mr, input logic mw, input logic m2r,
                           input logic rw, input logic br, input logic z, input logic [4:0] rd,
                           input logic [XLEN-1:0] addr, input logic [XLEN-1:0] wdata,
                           input logic [XLEN-1:0] pcb, input logic [XLEN-1:0] rdata, input int k);
    logic mem_op, mis, ack, fin;
    mem_op = mr | mw;
    mis    = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
    mis = mem_op && (addr[2:0] != 3'b000);
`endif
    mem_read_d3 = mr;  mem_write_d3 = mw;  mem_to_reg_d3 = m2r;  reg_write_d3 = rw;
    branch_d3 = br;    alu_zero_d3 = z;    rd_d3 = rd;
    alu_result_d3 = addr;  rs2_data_d3 = wdata;  pc_branch_d3 = pcb;
    for (int c = 0; c <= int'(TIMEOUT); c++) begin
      ack = mem_op && !mis && (c == k);
      // with no request outstanding a stray ack must be ignored
      dmem_ack   = (mem_op && !mis) ? ack : 1'($urandom_range(0, 1));
      dmem_rdata = ack ? rdata : rnd64();
      #1;
      check_val({tag, ".pc_src"},    XLEN'(pc_src), XLEN'(br & z));
      check_val({tag, ".pc_target"}, pc_target,     pcb);
      if (!mem_op || mis) begin
        check_val({tag, ".req"},     XLEN'(dmem_req), '0);
        check_val({tag, ".stall"},   XLEN'(stall),    '0);
        check_val({tag, ".bus_err"}, XLEN'(bus_err),  XLEN'(mis));
        @(posedge clk); #1;
        if (mis) begin
          check_d4({tag, ".mis"}, 1'b0, 1'b0, 5'd0);
        end else begin
          exp_alu = addr;
          check_d4({tag, ".alu"}, m2r, rw, rd);
        end
        @(negedge clk);
        break;
      end
      fin = ack || (c == int'(TIMEOUT));
      check_val({tag, ".req"},     XLEN'(dmem_req), 1);
      check_val({tag, ".we"},      XLEN'(dmem_we),  XLEN'(mw));
      check_val({tag, ".addr"},    dmem_addr,       addr);
      check_val({tag, ".wdata"},   dmem_wdata,      wdata);
      check_val({tag, ".stall"},   XLEN'(stall),    XLEN'(!fin));
      check_val({tag, ".bus_err"}, XLEN'(bus_err),  XLEN'(!ack && c == int'(TIMEOUT)));
      @(posedge clk); #1;
      if (!fin) begin
        check_d4({tag, ".wait"}, 1'b0, 1'b0, 5'd0);
      end else if (ack) begin
        exp_alu = addr;
        if (mr && !mw) exp_rdata = rdata;
        check_d4({tag, ".done"}, m2r, rw, rd);
      end else begin
        check_d4({tag, ".tmo"}, 1'b0, 1'b0, 5'd0);
      end
      @(negedge clk);
      if (fin) break;
    end
  endtask

  task automatic idle_inputs();
    mem_read_d3 = 1'b0;  mem_write_d3 = 1'b0;  mem_to_reg_d3 = 1'b0;  reg_write_d3 = 1'b0;
    branch_d3 = 1'b0;    alu_zero_d3 = 1'b0;   rd_d3 = '0;
    alu_result_d3 = '0;  rs2_data_d3 = '0;     pc_branch_d3 = '0;
    dmem_ack = 1'b0;     dmem_rdata = '0;
  endtask

  initial begin
    int op, k;
    logic [XLEN-1:0] a;
    idle_inputs();
    // reset with a live load on the inputs: nothing may leave the stage
    rst = 1'b1;
    mem_read_d3 = 1'b1;  dmem_ack = 1'b1;  alu_result_d3 = 64'h100;
    exp_alu = '0;  exp_rdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    check_val("rst.req",     XLEN'(dmem_req), '0);
    check_val("rst.stall",   XLEN'(stall),    '0);
    check_val("rst.bus_err", XLEN'(bus_err),  '0);
    check_d4("rst", 1'b0, 1'b0, 5'd0);
    @(negedge clk);
    rst = 1'b0;
    idle_inputs();

    run_instr("ld0", 1, 0, 1, 1, 0, 0, 5'd7, 64'h100, 64'h0, 64'h0, 64'hDEAD, 0);
    run_instr("st3", 0, 1, 0, 0, 0, 0, 5'd3, 64'h208, 64'h1234_5678_9ABC_DEF0, 64'h0, 64'h0, 3);
    run_instr("br1", 0, 0, 0, 0, 1, 1, 5'd0, 64'h11, 64'h0, 64'h40, 64'h0, 0);
    run_instr("br0", 0, 0, 0, 0, 1, 0, 5'd0, 64'h12, 64'h0, 64'h40, 64'h0, 0);
    run_instr("rw",  1, 1, 0, 1, 0, 0, 5'd9, 64'h300, 64'hCAFE, 64'h0, 64'hBAD, 1);

    // reset while the access is waiting
    mem_read_d3 = 1'b1;  reg_write_d3 = 1'b1;  rd_d3 = 5'd4;  alu_result_d3 = 64'h180;
    dmem_ack = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;  #1;
    check_val("rstw.req",     XLEN'(dmem_req), '0);
    check_val("rstw.stall",   XLEN'(stall),    '0);
    check_val("rstw.bus_err", XLEN'(bus_err),  '0);
    @(negedge clk);
    rst = 1'b0;
    idle_inputs();  #1;
    exp_alu = '0;  exp_rdata = '0;
    check_val("rstw.req2",   XLEN'(dmem_req), '0);
    check_val("rstw.stall2", XLEN'(stall),    '0);
    check_d4("rstw", 1'b0, 1'b0, 5'd0);
    @(negedge clk);

    run_instr("tmo",  1, 0, 1, 1, 0, 0, 5'd5, 64'h400, 64'h0, 64'h0, 64'h0, int'(TIMEOUT) + 5);
    run_instr("ackT", 1, 0, 1, 1, 0, 0, 5'd6, 64'h408, 64'h0, 64'h0, 64'h5A5A, int'(TIMEOUT));
    run_instr("al104", 1, 0, 1, 1, 0, 0, 5'd8, 64'h104, 64'h0, 64'h0, 64'hF00D, 0);

    for (int i = 0; i < 300; i++) begin
      op = int'($urandom_range(0, 4));
      k  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(TIMEOUT - 2, TIMEOUT + 3))
                                       : int'($urandom_range(0, 4));
      a  = rnd64();
      if ($urandom_range(0, 1) == 0) a[2:0] = 3'b000;
      case (op)
        0: run_instr("r.alu", 0, 0, 0, 1'($urandom), 0, 1'($urandom), 5'($urandom), a, rnd64(), rnd64(), rnd64(), k);
        1: run_instr("r.ld",  1, 0, 1, 1, 0, 1'($urandom), 5'($urandom), a, rnd64(), rnd64(), rnd64(), k);
        2: run_instr("r.st",  0, 1, 0, 0, 0, 1'($urandom), 5'($urandom), a, rnd64(), rnd64(), rnd64(), k);
        3: run_instr("r.br",  0, 0, 0, 0, 1, 1'($urandom), 5'($urandom), a, rnd64(), rnd64(), rnd64(), k);
        default: run_instr("r.rw", 1, 1, 1'($urandom), 1'($urandom), 0, 0, 5'($urandom), a, rnd64(), rnd64(), rnd64(), k);
      endcase
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
